// File: rtl/sm_fetch_buffer.sv
// sm_fetch_buffer: instruction prefetch stage between the node ROM and core decode.
// Drives the ROM word address, captures the combinational ROM word into a small
// FIFO, and hands entries to the core over valid/ready. Supports redirect/flush
// and stops fetching after the last ROM word.
module sm_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter int          ROM_SIZE = 128,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              im_addr,
  input  logic [31:0]              im_data,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [29:0]   ROM_WORDS = 30'(ROM_SIZE);
  localparam logic [29:0]   ROM_LAST  = 30'(ROM_SIZE - 1);

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  state_t         state_q;
  state_t         state_d;

  logic [31:0]    fetch_pc;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [31:0]    mem_data [DEPTH];
  logic [31:0]    mem_pc   [DEPTH];

  logic [29:0]    pc_word;
  logic           in_range;
  logic           at_last;
  logic           target_in_range;
  logic           push;
  logic           pop;
  logic           unused_pc_lsbs;

  // Address decode of the current fetch pointer and the redirect target
  always_comb begin
    pc_word         = fetch_pc[31:2];
    in_range        = (pc_word < ROM_WORDS);
    at_last         = (pc_word == ROM_LAST);
    target_in_range = (redirect_pc[31:2] < ROM_WORDS);
    unused_pc_lsbs  = ^redirect_pc[1:0];
  end

  // Handshake and fill qualifiers; a push never happens from an out-of-range address
  always_comb begin
    pop  = instr_valid & instr_ready;
    push = (state_q == FETCH) & in_range & ((count < DEPTH_C) | pop) & ~redirect;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state: redirect overrides, otherwise halt after the last word or on an out-of-range pc
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = target_in_range ? FETCH : HALT;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (push && at_last) state_d = HALT;
          else if (!in_range)  state_d = HALT;
        end
        HALT:    state_d = HALT;
        default: state_d = FETCH;
      endcase
    end
  end

  // Outputs: head is forced to zero when the FIFO is empty
  always_comb begin
    halted      = (state_q == HALT);
    instr_valid = (count != '0);
    instr       = instr_valid ? mem_data[rd_ptr] : '0;
    instr_pc    = instr_valid ? mem_pc[rd_ptr]   : '0;
    im_addr     = {2'b00, fetch_pc[31:2]};
  end

  // Fetch pointer, FIFO pointers and occupancy; redirect flushes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= im_data;
      mem_pc[wr_ptr]   <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_sm_fetch_buffer.sv
// Testbench for sm_fetch_buffer: directed phases with a pc/instr scoreboard.
module tb_sm_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam int          ROM_SIZE = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  count;
  logic        halted;

  logic [31:0] rom_img [ROM_SIZE];
  logic [63:0] sb [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  sm_fetch_buffer #(
    .DEPTH    (DEPTH),
    .ROM_SIZE (ROM_SIZE),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .im_addr     (im_addr),
    .im_data     (im_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .count       (count),
    .halted      (halted)
  );

  // Combinational ROM model
  assign im_data = (im_addr < 32'(ROM_SIZE)) ? rom_img[im_addr[4:0]] : 32'hDEAD_BEEF;

  initial begin
    for (int i = 0; i < ROM_SIZE; i++)
      rom_img[i] = 32'h5A00_0013 ^ (32'(i) << 12) ^ (32'(i) << 24);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected delivery order after a restart at target: sequential words to the ROM end
  task automatic load_seq(input logic [31:0] t);
    sb.delete();
    for (int unsigned w = 32'(t[31:2]); w < ROM_SIZE; w++)
      sb.push_back({32'(w) << 2, rom_img[w]});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every completed handshake against the scoreboard
  always @(negedge clk) begin : mon
    logic [63:0] e;
    if (!rst && !redirect) begin
      if (!instr_valid) begin
        chk("idle_zero", instr | instr_pc, 32'h0);
      end else if (instr_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got pc %h, expected no delivery at %0t", instr_pc, $time);
        end else begin
          e = sb.pop_front();
          chk("deliver_pc", instr_pc, e[63:32]);
          chk("deliver_instr", instr, e[31:0]);
        end
      end
    end
  end

  initial begin
    logic [31:0] t;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    cyc(); cyc();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_im_addr", im_addr, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);

    // Streaming with constant ready
    load_seq(RESET_PC);
    rst = 1'b0; instr_ready = 1'b1;
    cyc();
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_pc0", instr_pc, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t1_count", 32'(count), 32'd1);
    end

    // Back-pressure fill and full-with-pop
    rst = 1'b1; instr_ready = 1'b0;
    cyc();
    load_seq(RESET_PC);
    rst = 1'b0;
    repeat (8) cyc();
    chk("t2_count_full", 32'(count), 32'd4);
    chk("t2_im_addr", im_addr, 32'd4);
    chk("t2_head_pc", instr_pc, 32'h0);
    chk("t2_head_instr", instr, rom_img[0]);
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    chk("t2_count_pp", 32'(count), 32'd4);
    chk("t2_im_addr_pp", im_addr, 32'd5);
    chk("t2_head_pc_pp", instr_pc, 32'h4);

    // Redirect with 3 buffered entries
    rst = 1'b1;
    cyc();
    load_seq(RESET_PC);
    rst = 1'b0;
    repeat (3) cyc();
    chk("t3_count3", 32'(count), 32'd3);
    redirect = 1'b1; redirect_pc = 32'h43; load_seq(32'h43);
    cyc();
    redirect = 1'b0;
    chk("t3_flush_valid", 32'(instr_valid), 32'd0);
    chk("t3_flush_count", 32'(count), 32'd0);
    chk("t3_im_addr", im_addr, 32'd16);
    cyc();
    chk("t3_valid", 32'(instr_valid), 32'd1);
    chk("t3_pc", instr_pc, 32'h40);
    chk("t3_instr", instr, rom_img[16]);
    instr_ready = 1'b1;
    repeat (4) cyc();

    // End of ROM halt, resume, and out-of-range redirect
    redirect = 1'b1; redirect_pc = 32'h70; load_seq(32'h70);
    cyc();
    redirect = 1'b0;
    repeat (10) cyc();
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_valid", 32'(instr_valid), 32'd0);
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_all_delivered", 32'(sb.size()), 32'd0);
    chk("t4_im_addr", im_addr, 32'd32);
    redirect = 1'b1; redirect_pc = 32'h0; load_seq(32'h0);
    cyc();
    redirect = 1'b0;
    chk("t4_resume_halted", 32'(halted), 32'd0);
    repeat (3) cyc();
    chk("t4_resume_valid", 32'(instr_valid), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h80; load_seq(32'h80);
    cyc();
    redirect = 1'b0;
    chk("t4_oor_halted", 32'(halted), 32'd1);
    repeat (5) cyc();
    chk("t4_oor_valid", 32'(instr_valid), 32'd0);
    chk("t4_oor_count", 32'(count), 32'd0);
    chk("t4_oor_im_addr", im_addr, 32'd32);

    // Reset mid-stream with count=3, fetch_pc=0x30
    instr_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h24; load_seq(32'h24);
    cyc();
    redirect = 1'b0;
    repeat (3) cyc();
    chk("t5_count3", 32'(count), 32'd3);
    chk("t5_im_addr", im_addr, 32'd12);
    rst = 1'b1; load_seq(RESET_PC);
    cyc();
    rst = 1'b0;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_valid", 32'(instr_valid), 32'd0);
    chk("t5_instr", instr, 32'd0);
    chk("t5_pc", instr_pc, 32'd0);
    chk("t5_halted", 32'(halted), 32'd0);
    chk("t5_im_addr", im_addr, 32'd0);
    instr_ready = 1'b1;
    repeat (5) cyc();

    // Random ready and random redirects
    for (int i = 0; i < 1000; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        t = 32'($urandom_range(0, ROM_SIZE + 3)) * 32'd4 + 32'($urandom_range(0, 3));
        redirect = 1'b1; redirect_pc = t; load_seq(t);
      end else begin
        redirect = 1'b0;
      end
      cyc();
    end
    redirect = 1'b1; redirect_pc = 32'h60; load_seq(32'h60);
    instr_ready = 1'b1;
    cyc();
    redirect = 1'b0;
    repeat (40) cyc();
    chk("t6_drained", 32'(sb.size()), 32'd0);
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_valid", 32'(instr_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_fetch_buffer.md
Name: sm_fetch_buffer

Overview:
Instruction prefetch stage that sits between the per-node instruction ROM and the schoolRISCV core decode. It drives the ROM word address and captures the combinational ROM output. Fetched words go into a small FIFO and are handed to the core over a valid/ready handshake. Supports flush/redirect on taken branch or jump, and stops fetching at the end of the ROM.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
ROM_SIZE, 128, ROM size in 32-bit words; must match the ROM instance
RESET_PC, 32'h0, byte address fetched first after reset; word-aligned

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
im_addr  output  32  ROM word address = {2'b0, fetch_pc[31:2]}
im_data  input  32  ROM read data, combinational from im_addr, same cycle
redirect  input  1  flush FIFO and restart fetch at redirect_pc
redirect_pc  input  32  new byte address; bits [1:0] ignored
instr  output  32  instruction at FIFO head
instr_pc  output  32  byte address of instr
instr_valid  output  1  FIFO non-empty
instr_ready  input  1  consumer accepts head this cycle
count  output  $clog2(DEPTH)+1  current FIFO occupancy
halted  output  1  fetch stopped at end of ROM

Behaviour:
- Reset (rst=1 at edge):
  - fetch_pc=RESET_PC, count=0, rd/wr pointers=0, state=FETCH.
  - Outputs: instr_valid=0, instr=0, instr_pc=0, count=0, halted=0, im_addr=RESET_PC>>2.
  - FIFO storage is not reset.
- Reset mid-operation discards all buffered entries and any pending redirect.
- instr and instr_pc are driven to 0 whenever instr_valid=0. instr_valid = (count!=0).
- pop = instr_valid & instr_ready.
- push = (state==FETCH) & (count<DEPTH | pop) & ~redirect.
- On push: write {fetch_pc, im_data} at wr_ptr, wr_ptr+1 mod DEPTH, fetch_pc+=4.
- Latency: a word pushed at edge N is visible at the head from cycle N+1 if the FIFO was empty. No combinational bypass from im_data to instr.
- Full with simultaneous pop: push proceeds, count unchanged.
- Empty: pop impossible; instr_ready ignored.
- count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- State machine:
  - FETCH: on push where fetch_pc[31:2]==ROM_SIZE-1, go to HALT (fetch_pc still advances).
  - FETCH: if fetch_pc[31:2]>=ROM_SIZE with no push, go to HALT; no push from an out-of-range address, ever.
  - HALT: no pushes, halted=1, FIFO drains normally via pop.
  - HALT -> FETCH only on redirect with redirect_pc[31:2]<ROM_SIZE.
- Redirect (highest priority below rst):
  - At the edge, count=0, pointers=0, fetch_pc={redirect_pc[31:2],2'b00}.
  - State becomes FETCH if the target is in range, else HALT.
  - No push that cycle. A pop in the same cycle is a completed handshake from the consumer's view, but the flush discards the rest.
  - First post-redirect instruction has instr_valid=1 two cycles after the redirect cycle (one edge to redirect, one edge to push).
- instr_valid does not depend combinationally on redirect or instr_ready. The consumer must ignore the head during the redirect cycle.
- Back-to-back redirects: the latest one wins, and no entries are pushed between them.
- fetch_pc arithmetic is 32-bit wrap. The ROM range check prevents reaching wrap in practice.

Test Plan:
1. Reset, then instr_ready=1 constantly → instr_valid rises 1 cycle after reset release. Stream instr_pc=0x0,0x4,0x8,... with instr = ROM words 0,1,2,...; count stays at 1.
2. Hold instr_ready=0 for 8 cycles → count saturates at 4, im_addr holds at 4, instr_pc at head stays 0x0. Then a single-cycle ready pops 0x0 and pushes word 4, count stays 4.
3. Buffer 3 entries, assert redirect with redirect_pc=0x43 for one cycle → next cycle instr_valid=0 and count=0. The following cycle instr_valid=1, instr_pc=0x40, instr=ROM word 16.
4. ROM_SIZE=8, instr_ready=1 → last delivered instr_pc=0x1C, then halted=1 and instr_valid=0 permanently. A redirect to 0x0 resumes with instr_pc=0x0. A redirect to 0x20 keeps halted=1 with no pushes.
5. Assert rst for one cycle mid-stream with count=3 and fetch_pc=0x30 → all outputs return to reset values and fetch restarts at RESET_PC. No stale entry ever appears with instr_valid=1.
6. Random instr_ready with a scoreboard against the ROM image over 1000 cycles, including random redirects → every delivered pair satisfies instr==ROM[instr_pc>>2]. instr_pc is strictly sequential (+4) between redirects, with no loss or duplication.
